// File: rtl/ema_trend_detector_pkg.sv
// rtl/ema_trend_detector_pkg.sv - shared Q8.8 constants and trend/state types for the series preprocessing chain
package ema_trend_detector_pkg;

    localparam int Q88_W    = 16;
    localparam int Q88_FRAC = 8;

    typedef enum logic [1:0] {
        TREND_FLAT = 2'b00,
        TREND_UP   = 2'b01,
        TREND_DOWN = 2'b10
    } trend_e;

    // Trend states share the trend_e encoding so the output is a plain copy; INIT takes the spare code.
    typedef enum logic [1:0] {
        ST_FLAT = 2'b00,
        ST_UP   = 2'b01,
        ST_DOWN = 2'b10,
        ST_INIT = 2'b11
    } state_e;

    function automatic trend_e state_to_trend(input state_e s);
        return (s == ST_INIT) ? TREND_FLAT : trend_e'(s);
    endfunction

endpackage

// File: rtl/ema_trend_detector_sat_diff_q88.sv
// rtl/ema_trend_detector_sat_diff_q88.sv - combinational Q8.8 subtract with full-precision and clamped results
module sat_diff_q88
    import ema_trend_detector_pkg::*;
(
    input  logic [Q88_W-1:0] a,
    input  logic [Q88_W-1:0] b,
    output logic [Q88_W:0]   diff,
    output logic [Q88_W-1:0] sat
);

    always_comb begin
        diff = {a[Q88_W-1], a} - {b[Q88_W-1], b};
        sat  = diff[Q88_W-1:0];
        // Top two bits disagree only when the true difference leaves the 16-bit range.
        if (diff[Q88_W] != diff[Q88_W-1]) begin
            sat = diff[Q88_W] ? {1'b1, {(Q88_W-1){1'b0}}} : {1'b0, {(Q88_W-1){1'b1}}};
        end
    end

endmodule

// File: rtl/ema_trend_detector.sv
// rtl/ema_trend_detector.sv - EMA slope, hysteresis trend FSM with dwell debounce; TREND_STATS_EN adds transition counters
module ema_trend_detector
    import ema_trend_detector_pkg::*;
#(
    parameter logic [15:0] THRESH = 16'd8,
    parameter logic [3:0]  DWELL  = 4'd3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        valid,
    input  logic [15:0] ema_in,
    output logic [15:0] slope_out,
    output logic [1:0]  trend,
    output logic        trend_change,
    output logic        output_valid
`ifdef TREND_STATS_EN
    ,
    output logic [15:0] up_count,
    output logic [15:0] down_count
`endif
);

    localparam logic [3:0]         DWELL_EFF = (DWELL == 4'd0) ? 4'd1 : DWELL;
    localparam logic signed [16:0] POS_TH    = $signed({1'b0, THRESH});
    localparam logic signed [16:0] NEG_TH    = -POS_TH;

    state_e      state_q, state_d;
    trend_e      pending_q, pending_d;
    trend_e      cur_trend, cand;
    logic [15:0] prev_q, prev_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [15:0] slope_d;
    logic        change_d, ovalid_d;
    logic [16:0] diff;
    logic [15:0] diff_sat;

    sat_diff_q88 u_sat_diff (
        .a    (ema_in),
        .b    (prev_q),
        .diff (diff),
        .sat  (diff_sat)
    );

    assign cur_trend = state_to_trend(state_q);
    assign trend     = cur_trend;

    // Hysteresis uses the unclamped difference so a clamped slope still classifies correctly.
    always_comb begin
        cand = TREND_FLAT;
        if ($signed(diff) > POS_TH) begin
            cand = TREND_UP;
        end else if ($signed(diff) < NEG_TH) begin
            cand = TREND_DOWN;
        end
    end

    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        prev_d    = prev_q;
        cnt_d     = cnt_q;
        slope_d   = slope_out;
        change_d  = 1'b0;
        ovalid_d  = 1'b0;
        if (valid) begin
            prev_d = ema_in;
            if (state_q == ST_INIT) begin
                state_d = ST_FLAT;
            end else begin
                ovalid_d = 1'b1;
                slope_d  = diff_sat;
                if (cand == cur_trend) begin
                    cnt_d     = 4'd0;
                    pending_d = cur_trend;
                end else if (cand == pending_q) begin
                    cnt_d = (cnt_q == 4'hF) ? cnt_q : cnt_q + 4'd1;
                end else begin
                    pending_d = cand;
                    cnt_d     = 4'd1;
                end
                if ((cand != cur_trend) && (cnt_d >= DWELL_EFF)) begin
                    state_d  = state_e'(pending_d);
                    change_d = 1'b1;
                    cnt_d    = 4'd0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_INIT;
            pending_q    <= TREND_FLAT;
            prev_q       <= '0;
            cnt_q        <= '0;
            slope_out    <= '0;
            trend_change <= 1'b0;
            output_valid <= 1'b0;
        end else begin
            state_q      <= state_d;
            pending_q    <= pending_d;
            prev_q       <= prev_d;
            cnt_q        <= cnt_d;
            slope_out    <= slope_d;
            trend_change <= change_d;
            output_valid <= ovalid_d;
        end
    end

`ifdef TREND_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            up_count   <= '0;
            down_count <= '0;
        end else if (change_d) begin
            if ((pending_d == TREND_UP) && (up_count != 16'hFFFF)) begin
                up_count <= up_count + 16'd1;
            end
            if ((pending_d == TREND_DOWN) && (down_count != 16'hFFFF)) begin
                down_count <= down_count + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_ema_trend_detector.sv
// tb/tb_ema_trend_detector.sv - scoreboard bench for ema_trend_detector with a queue-based trend reference model
module tb_ema_trend_detector;

    localparam logic [15:0] TH    = 16'd8;
    localparam logic [3:0]  DW    = 4'd3;
    localparam int          DWN   = (DW == 4'd0) ? 1 : int'(DW);

    typedef struct {
        logic [15:0] slope;
        logic [1:0]  trend;
        logic        chg;
        logic [15:0] ups;
        logic [15:0] downs;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        valid = 1'b0;
    logic [15:0] ema_in = '0;
    logic [15:0] slope_out;
    logic [1:0]  trend;
    logic        trend_change;
    logic        output_valid;
`ifdef TREND_STATS_EN
    logic [15:0] up_count;
    logic [15:0] down_count;
`endif

    int checks = 0;
    int errors = 0;

    exp_t        exp_q[$];
    bit          primed;
    logic [15:0] m_prev;
    int          m_trend;
    int          run_q[$];
    int          m_ups, m_downs;
    logic [15:0] cur_val;

    ema_trend_detector #(.THRESH(TH), .DWELL(DW)) dut (
        .clk          (clk),
        .reset        (reset),
        .valid        (valid),
        .ema_in       (ema_in),
        .slope_out    (slope_out),
        .trend        (trend),
        .trend_change (trend_change),
        .output_valid (output_valid)
`ifdef TREND_STATS_EN
        ,
        .up_count     (up_count),
        .down_count   (down_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int classify(input int d);
        if (d > int'(TH)) return 1;
        if (d < -int'(TH)) return 2;
        return 0;
    endfunction

    // Trend switches once DWN consecutive identical candidates, all differing from the trend, have been seen.
    task automatic model_step(input logic [15:0] x);
        int   d, c;
        exp_t e;
        if (!primed) begin
            primed = 1'b1;
            m_prev = x;
            return;
        end
        d      = int'($signed(x)) - int'($signed(m_prev));
        m_prev = x;
        c      = classify(d);
        e.chg  = 1'b0;
        if (c == m_trend) begin
            run_q.delete();
        end else begin
            if (run_q.size() > 0 && run_q[$] != c) run_q.delete();
            run_q.push_back(c);
            if (run_q.size() >= DWN) begin
                m_trend = c;
                e.chg   = 1'b1;
                run_q.delete();
                if (c == 1 && m_ups < 65535) m_ups++;
                if (c == 2 && m_downs < 65535) m_downs++;
            end
        end
        e.slope = (d > 32767) ? 16'h7FFF : (d < -32768) ? 16'h8000 : 16'(d);
        e.trend = 2'(m_trend);
        e.ups   = 16'(m_ups);
        e.downs = 16'(m_downs);
        exp_q.push_back(e);
    endtask

    task automatic model_reset();
        primed  = 1'b0;
        m_prev  = '0;
        m_trend = 0;
        m_ups   = 0;
        m_downs = 0;
        run_q.delete();
    endtask

    task automatic send(input logic [15:0] x);
        @(posedge clk);
        #2;
        valid   = 1'b1;
        ema_in  = x;
        cur_val = x;
        model_step(x);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
            valid = 1'b0;
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2;
        valid = 1'b0;
        reset = 1'b1;
        check("drained_before_reset", exp_q.size(), 0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_slope", slope_out, 0);
        check("rst_trend", trend, 0);
        check("rst_change", trend_change, 0);
        check("rst_ovalid", output_valid, 0);
`ifdef TREND_STATS_EN
        check("rst_up_count", up_count, 0);
        check("rst_down_count", down_count, 0);
`endif
        model_reset();
        @(posedge clk);
        #2;
        reset = 1'b0;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (output_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output: output_valid=1 expected no output at %0t", $time);
                end else begin
                    e = exp_q.pop_front();
                    check("slope_out", slope_out, e.slope);
                    check("trend", trend, e.trend);
                    check("trend_change", trend_change, e.chg);
`ifdef TREND_STATS_EN
                    check("up_count", up_count, e.ups);
                    check("down_count", down_count, e.downs);
`endif
                end
            end else if (trend_change) begin
                checks++;
                errors++;
                $display("FAIL stray_trend_change: trend_change=1 output_valid=0 at %0t", $time);
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin : driver
        model_reset();
        do_reset();

        // single priming sample gives no output
        send(16'h0100);
        idle(3);
        @(negedge clk);
        check("prime_trend_flat", trend, 0);
        check("prime_no_output", exp_q.size(), 0);

        // +0x10 steps confirm UP on the third output
        send(16'h0110); send(16'h0120); send(16'h0130);
        idle(2);

        // steps of exactly THRESH stay FLAT
        do_reset();
        send(16'h0200);
        for (int i = 1; i <= 6; i++) send(16'h0200 + 16'(8 * i));
        idle(2);
        @(negedge clk);
        check("thresh_edge_flat", trend, 0);

        // large negative step saturates
        do_reset();
        send(16'h7F00); send(16'h8000);
        idle(2);

        // UP then DOWN, FLAT, DOWN, DOWN, DOWN
        do_reset();
        send(16'h0000); send(16'h0020); send(16'h0040); send(16'h0060);
        send(16'h0040); send(16'h0040); send(16'h0020); send(16'h0000); send(16'hFFE0);
        idle(2);
        @(negedge clk);
        check("up_to_down_direct", trend, 2);

        // reset mid-dwell, then replay
        do_reset();
        send(16'h0100); send(16'h0110); send(16'h0120);
        idle(2);
        do_reset();
        send(16'h0100); send(16'h0110); send(16'h0120);
        idle(2);
        @(negedge clk);
        check("replay_still_flat", trend, 0);
        send(16'h0130);
        idle(2);

        // randomized stream with gaps, bursts and occasional resets
        do_reset();
        cur_val = 16'(int'($urandom_range(0, 16'hFFFF)));
        for (int i = 0; i < 500; i++) begin
            logic [15:0] nv;
            if ($urandom_range(0, 59) == 0) begin
                idle(1);
                do_reset();
            end
            if ($urandom_range(0, 7) == 0)
                nv = 16'($urandom_range(0, 16'hFFFF));
            else
                nv = cur_val + 16'(int'($urandom_range(0, 48)) - 24);
            send(nv);
            if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 2)));
        end
        idle(4);
        check("scoreboard_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ema_trend_detector.md
Name: ema_trend_detector

Overview:
Downstream consumer of the EMA stage in the series preprocessing chain. It takes the Q8.8 EMA stream and its valid pulse, then computes the per-sample slope. It classifies the trend as FLAT, UP or DOWN, using a hysteresis threshold and a dwell (debounce) counter. Its outputs are the saturated slope, the confirmed trend, and a one-cycle pulse when the trend changes.

Parameters:
THRESH, 16'd8, unsigned Q8.8 slope magnitude (0.03125) that must be strictly exceeded to count as UP or DOWN.
DWELL, 4'd3, number of consecutive samples with the same new classification needed to confirm a trend change. A value of 0 is treated as 1.

Ports:
clk  input  1  single system clock, rising edge.
reset  input  1  synchronous, active-high reset.
valid  input  1  one-cycle pulse from the EMA stage; a new sample is present on ema_in.
ema_in  input  16  signed Q8.8 EMA sample.
slope_out  output  16  signed Q8.8 value of (ema_in − previous sample), saturated.
trend  output  2  confirmed trend: 2'b00 FLAT, 2'b01 UP, 2'b10 DOWN. 2'b11 is never driven.
trend_change  output  1  one-cycle pulse on the cycle that trend takes a new value.
output_valid  output  1  one-cycle pulse; slope_out and trend are updated on this cycle.

Behaviour:
- Reset is synchronous and active-high (one clock, clk). While reset is high:
  - slope_out=0, trend=FLAT, trend_change=0, output_valid=0.
  - Internal state: FSM=INIT, prev=0, pending=FLAT, dwell_cnt=0.
  - valid is ignored.
- FSM states: INIT, FLAT, UP, DOWN. The trend output mirrors FLAT, UP or DOWN, and shows FLAT while in INIT.
- INIT: the first valid stores ema_in into prev and moves to FLAT. No output_valid is produced for this sample.
- Every later valid, registered result on the next edge (latency 1 cycle, with output_valid high for exactly that cycle):
  - diff = sext17(ema_in) − sext17(prev).
  - slope_out = diff clamped to [0x8000, 0x7FFF].
  - prev <= ema_in.
- Classification candidate, using the unsaturated 17-bit diff:
  - diff > +THRESH → UP.
  - diff < −THRESH → DOWN.
  - Otherwise FLAT. A diff exactly equal to ±THRESH is FLAT.
- Dwell logic, evaluated on each valid:
  - candidate == current trend: dwell_cnt <= 0, pending <= current trend.
  - candidate != current and candidate == pending: dwell_cnt increments, saturating at 15.
  - candidate != current and candidate != pending: pending <= candidate, dwell_cnt <= 1.
  - When the updated count reaches max(DWELL,1), the FSM moves to pending, trend_change pulses together with output_valid, and dwell_cnt resets to 0.
  - An UP→DOWN transition is allowed directly; it does not pass through FLAT.
- valid may be asserted on back-to-back cycles; every pulse is processed, so throughput is 1 sample per clock. There is no backpressure.
- trend_change and output_valid default to 0 on every cycle without a processed sample.
- Reset asserted mid-stream: all state is discarded, and the next valid after reset re-primes from INIT.

Optional Feature:
TREND_STATS_EN:
- Defined: adds output ports up_count[15:0] and down_count[15:0]. These are saturating counts (stick at 0xFFFF) of confirmed transitions into UP and into DOWN, cleared by reset and updated on the same edge as trend_change.
- Undefined: these ports and their counters do not exist, and the core behaviour is identical.

Decomposition:
- Shared package: a trend_e enum (FLAT=2'b00, UP=2'b01, DOWN=2'b10), the Q8.8 width constant (16), and the fractional-bits constant (8), reused by the EMA stage.
- One natural sub-module, sat_diff_q88: a combinational 17-bit subtract with clamp to 16 bits, also usable elsewhere in the chain.
- The FSM and dwell counter stay in the top module.

Test Plan:
1. Reset, then a single valid with ema_in=0x0100 → no output_valid; trend=FLAT.
2. Samples 0x0100, 0x0110, 0x0120, 0x0130 (diff 0x10 > 8), DWELL=3 → slope_out=0x0010 on each; trend_change and trend=UP only on the 3rd output_valid.
3. Samples stepping by exactly +8 → slope_out=0x0008; trend stays FLAT; trend_change never asserts.
4. Sample 0x7F00 then 0x8000 (−128.0) → diff=−65280 clamped; slope_out=0x8000; candidate DOWN.
5. While in UP, candidates DOWN, FLAT, DOWN, DOWN, DOWN → the interleaved FLAT resets pending; trend=DOWN only after the 3rd consecutive DOWN.
6. Reset asserted after 2 of 3 dwell samples, then the same sample sequence is replayed → first sample re-primes; trend remains FLAT until a full DWELL run completes. With TREND_STATS_EN defined, up_count and down_count read 0 after reset.
